// File: rtl/game_countdown_timer_pkg.sv
// Shared definitions for the game countdown timer: state encoding,
// the largest legal BCD digit and the load-time digit saturation helper.
package game_countdown_timer_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Clamp a nibble into the BCD range so a bad load value still shows digits.
   function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
      return (nibble > BCD_MAX) ? BCD_MAX : nibble;
   endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// Control/status bundle between the game logic (master) and the timer (slave).
interface game_countdown_timer_if #(
   parameter int DIGITS = 3
);

   logic                  tick_in;
   logic                  load;
   logic [4*DIGITS-1:0]   load_value;
   logic                  reload_en;
   logic                  start;
   logic                  pause;
   logic [4*DIGITS-1:0]   count_bcd;
   logic                  running;
   logic                  unit_tick;
   logic                  expired;
   logic                  zero;

   modport master (
      output tick_in, load, load_value, reload_en, start, pause,
      input  count_bcd, running, unit_tick, expired, zero
   );

   modport slave (
      input  tick_in, load, load_value, reload_en, start, pause,
      output count_bcd, running, unit_tick, expired, zero
   );

endinterface

// File: rtl/game_countdown_timer_bcd_digit.sv
// One BCD digit of the down counter. A digit decrements only when the
// whole chain below it is borrowing, and wraps 0 -> 9 while passing the
// borrow up to the next digit.
module bcd_digit_down
   import game_countdown_timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_digit,
   input  logic       dec_en,
   input  logic       borrow_in,
   output logic [3:0] digit,
   output logic       borrow_out
);

   logic [3:0] digit_q, digit_d;

   // Next digit value: load has priority over a decrement step.
   always_comb begin
      digit_d = digit_q;
      if (load) begin
         digit_d = load_digit;
      end else if (dec_en && borrow_in) begin
         digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      end
   end

   // Digit register.
   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit      = digit_q;
   assign borrow_out = borrow_in && (digit_q == 4'd0);

endmodule

// File: rtl/game_countdown_timer.sv
// BCD countdown timer: divides tick_in by TICKS_PER_UNIT and counts a
// DIGITS-wide BCD value down to zero, either once or with auto-reload.
module game_countdown_timer
   import game_countdown_timer_pkg::*;
#(
   parameter int TICKS_PER_UNIT = 1000,
   parameter int DIGITS         = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   game_countdown_timer_if.slave bus
);

   localparam int CW      = 4 * DIGITS;
   localparam int PRESC_W = $clog2(TICKS_PER_UNIT + 1);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_UNIT - 1);

   logic [1:0]         state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [CW-1:0]      reload_q, reload_d;
   logic               unit_tick_q, unit_tick_d;
   logic               expired_q, expired_d;

   logic [CW-1:0]      count;
   logic [CW-1:0]      load_sat;
   logic [CW-1:0]      digit_load_value;
   logic [DIGITS:0]    borrow;
   logic               count_zero;
   logic               term_tick;
   logic               dec_en;
   logic               expire_now;
   logic               reload_now;
   logic               digit_load;

   // Saturate every incoming load nibble into the BCD range.
   always_comb begin
      load_sat = '0;
      for (int i = 0; i < DIGITS; i++) begin
         load_sat[4*i +: 4] = bcd_sat(bus.load_value[4*i +: 4]);
      end
   end

   // The borrow chain is seeded with 1, so a borrow out of the top digit
   // means every digit is zero.
   assign borrow[0]  = 1'b1;
   assign count_zero = borrow[DIGITS];

   // Load and pause take precedence over a tick arriving in the same cycle.
   assign term_tick  = (state_q == ST_RUN) && bus.tick_in && !bus.load &&
                       !bus.pause && (presc_q == PRESC_LAST);
   assign dec_en     = term_tick && !count_zero;
   assign expire_now = dec_en && (count == CW'(1));
   assign reload_now = expire_now && bus.reload_en && (reload_q != '0);

   assign digit_load       = bus.load || reload_now;
   assign digit_load_value = bus.load ? load_sat : reload_q;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_digit
         bcd_digit_down u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (digit_load),
            .load_digit (digit_load_value[4*g +: 4]),
            .dec_en     (dec_en),
            .borrow_in  (borrow[g]),
            .digit      (count[4*g +: 4]),
            .borrow_out (borrow[g+1])
         );
      end
   endgenerate

   // Control FSM and prescaler: load > pause > start > tick counting.
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      reload_d    = reload_q;
      unit_tick_d = 1'b0;
      expired_d   = 1'b0;
      if (bus.load) begin
         state_d  = ST_IDLE;
         presc_d  = '0;
         reload_d = load_sat;
      end else if (bus.pause) begin
         if (state_q == ST_RUN) begin
            state_d = ST_PAUSED;
         end
      end else if (bus.start && (state_q == ST_IDLE || state_q == ST_PAUSED)) begin
         if (count_zero) begin
            state_d   = ST_DONE;
            expired_d = 1'b1;
         end else begin
            state_d = ST_RUN;
         end
      end else if ((state_q == ST_RUN) && bus.tick_in) begin
         if (presc_q == PRESC_LAST) begin
            presc_d     = '0;
            unit_tick_d = dec_en;
            expired_d   = expire_now;
            if (expire_now && !reload_now) begin
               state_d = ST_DONE;
            end
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   // State, prescaler, reload and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         reload_q    <= '0;
         unit_tick_q <= 1'b0;
         expired_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         reload_q    <= reload_d;
         unit_tick_q <= unit_tick_d;
         expired_q   <= expired_d;
      end
   end

   assign bus.count_bcd = count;
   assign bus.running   = (state_q == ST_RUN);
   assign bus.unit_tick = unit_tick_q;
   assign bus.expired   = expired_q;
   assign bus.zero      = count_zero;

endmodule
